mul_result_writer: RTL and testbench



---
 rtl/mul_result_writer.sv | 189 ++++++++++++++++++
 tb/tb_mul_result_writer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_writer.sv
// Writeback stage behind the SIMD multiplier: buffers results and issues one VRF word write per result.
// Optional grant-stall counter is enabled with `define MUL_RESULT_WRITER_STALL_CNT_EN.
module mul_result_writer #(
    parameter int Depth        = 2,
    parameter int DataWidth    = 64,
    parameter int StrbWidth    = DataWidth / 8,
    parameter int AddrWidth    = 10,
    parameter int VlBytesWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_valid_i,
    output logic                    instr_ready_o,
    input  logic [VlBytesWidth-1:0] instr_vl_bytes_i,
    input  logic [AddrWidth-1:0]    instr_addr_i,
    input  logic [DataWidth-1:0]    result_i,
    input  logic [StrbWidth-1:0]    mask_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic                    wr_req_o,
    input  logic                    wr_gnt_i,
    output logic [AddrWidth-1:0]    wr_addr_o,
    output logic [DataWidth-1:0]    wr_data_o,
    output logic [StrbWidth-1:0]    wr_be_o,
    output logic                    done_o,
    output logic [31:0]             stall_cnt_o
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntWidth = PtrWidth + 1;
    localparam int ShiftW   = (StrbWidth > 1) ? $clog2(StrbWidth) : 1;
    localparam logic [VlBytesWidth-1:0] StrbBytes = VlBytesWidth'(StrbWidth);
    localparam logic [CntWidth-1:0]     FullCount = CntWidth'(Depth);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic [AddrWidth-1:0]    addr;
    logic [VlBytesWidth-1:0] remaining;
    logic [VlBytesWidth-1:0] total_words;
    logic [VlBytesWidth-1:0] accepted_words;
    logic [VlBytesWidth-1:0] vl_words;
    logic [VlBytesWidth-1:0] retire_bytes;

    logic [DataWidth-1:0]    fifo_data [Depth];
    logic [StrbWidth-1:0]    fifo_mask [Depth];
    logic [PtrWidth-1:0]     wr_ptr;
    logic [PtrWidth-1:0]     rd_ptr;
    logic [CntWidth-1:0]     count;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic                    instr_accept;
    logic                    last_word;
    logic [StrbWidth-1:0]    tail_mask;

    assign fifo_full    = (count == FullCount);
    assign fifo_empty   = (count == '0);
    assign instr_ready_o = (state == IDLE);
    assign instr_accept = instr_valid_i & instr_ready_o;

    // Valid/ready: a beat moves when both are high at a rising edge; ready_o never looks at valid_i.
    assign ready_o = (state == ACTIVE) & ~fifo_full & (accepted_words < total_words);
    assign push    = valid_i & ready_o;
    assign wr_req_o = (state == ACTIVE) & ~fifo_empty;
    assign pop     = wr_req_o & wr_gnt_i;
    assign done_o  = (state == DONE);

    // Words needed to cover the lane's bytes, rounded up to whole words.
    assign vl_words = (instr_vl_bytes_i >> ShiftW)
                    + VlBytesWidth'(|instr_vl_bytes_i[ShiftW-1:0]);

    assign last_word    = (remaining <= StrbBytes);
    assign retire_bytes = last_word ? remaining : StrbBytes;

    always_comb begin
        tail_mask = '0;
        for (int i = 0; i < StrbWidth; i++) begin
            tail_mask[i] = (remaining > VlBytesWidth'(i));
        end
    end

    always_comb begin
        wr_addr_o = '0;
        wr_data_o = '0;
        wr_be_o   = '0;
        if (wr_req_o) begin
            wr_addr_o = addr;
            wr_data_o = fifo_data[rd_ptr];
            wr_be_o   = fifo_mask[rd_ptr] & tail_mask;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (instr_accept) begin
                    state_next = (instr_vl_bytes_i == '0) ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                if (pop && last_word) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            addr           <= '0;
            remaining      <= '0;
            total_words    <= '0;
            accepted_words <= '0;
        end else begin
            state <= state_next;
            if (instr_accept) begin
                addr           <= instr_addr_i;
                remaining      <= instr_vl_bytes_i;
                total_words    <= vl_words;
                accepted_words <= '0;
            end else begin
                if (push) begin
                    accepted_words <= accepted_words + VlBytesWidth'(1);
                end
                if (pop) begin
                    addr      <= addr + AddrWidth'(1);
                    remaining <= remaining - retire_bytes;
                end
            end
        end
    end

    // Storage needs no reset: the payload is gated off whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= result_i;
            fifo_mask[wr_ptr] <= mask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef MUL_RESULT_WRITER_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (instr_accept) begin
            stall_cnt <= '0;
        end else if (wr_req_o && !wr_gnt_i && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mul_result_writer.sv
// Self-checking bench for mul_result_writer: vector table of whole instructions plus stall and reset sequences.
module tb_mul_result_writer;

    localparam int DW    = 64;
    localparam int SW    = 8;
    localparam int AW    = 10;
    localparam int VW    = 16;
    localparam int EXP_W = AW + DW + SW + 1;
`ifdef MUL_RESULT_WRITER_STALL_CNT_EN
    localparam int EXP_STALL = 5;
`else
    localparam int EXP_STALL = 0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] be;
        logic          last;
    } exp_t;

    typedef struct {
        logic [VW-1:0] vl;
        logic [AW-1:0] addr;
        logic [SW-1:0] mask;
        int            extra;
        int            gnt_mode;
        int            words;
        logic [SW-1:0] last_be;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [VW-1:0] instr_vl = '0;
    logic [AW-1:0] instr_addr = '0;
    logic [DW-1:0] result = '0;
    logic [SW-1:0] mask_in = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic          wr_req;
    logic          wr_gnt = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_be;
    logic          done;
    logic [31:0]   stall_cnt;

    logic [EXP_W-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            done_due = -1;
    int            done_cnt = 0;
    int            write_cnt = 0;
    logic [SW-1:0] last_be = '0;
    vec_t          vecs[9];

    mul_result_writer dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_valid_i   (instr_valid),
        .instr_ready_o   (instr_ready),
        .instr_vl_bytes_i(instr_vl),
        .instr_addr_i    (instr_addr),
        .result_i        (result),
        .mask_i          (mask_in),
        .valid_i         (valid),
        .ready_o         (ready),
        .wr_req_o        (wr_req),
        .wr_gnt_i        (wr_gnt),
        .wr_addr_o       (wr_addr),
        .wr_data_o       (wr_data),
        .wr_be_o         (wr_be),
        .done_o          (done),
        .stall_cnt_o     (stall_cnt)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout cycles=%0d limit=40000", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] tail_of(input int rem);
        logic [SW-1:0] ones;
        ones = '1;
        if (rem >= SW) return ones;
        return ones >> (SW - rem);
    endfunction

    function automatic logic [EXP_W-1:0] mk_exp(input logic [VW-1:0] vl, input logic [AW-1:0] base,
                                                input logic [SW-1:0] mask, input logic [DW-1:0] data,
                                                input int k, input int words);
        exp_t e;
        e.addr = base + AW'(k);
        e.data = data;
        e.be   = mask & tail_of(int'(vl) - SW * k);
        e.last = (k == words - 1);
        return e;
    endfunction

    // Scoreboard: pop on every granted write, and check done timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (instr_valid && instr_ready && instr_vl == '0) done_due = cyc + 1;
            if (wr_req && wr_gnt) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual_addr=%0h expected=none", wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_data", wr_data, e.data);
                    chk("wr_be", 64'(wr_be), 64'(e.be));
                    last_be = wr_be;
                    if (e.last) done_due = cyc + 1;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_timing", 64'(cyc), 64'(done_due));
            end
        end
    end

    // Driver tasks
    task automatic start_instr(input logic [VW-1:0] vl, input logic [AW-1:0] addr);
        int g;
        g = 0;
        while (!instr_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk("instr_ready_wait", 64'(instr_ready), 64'd1);
        instr_valid = 1'b1;
        instr_vl    = vl;
        instr_addr  = addr;
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic feed(input logic [VW-1:0] vl, input logic [AW-1:0] addr, input logic [SW-1:0] mask,
                        input int first, input int last_idx, input int words, input int gnt_mode);
        int k;
        int g;
        k = first;
        g = 0;
        while (k < last_idx && g < 200) begin
            valid   = 1'b1;
            result  = {$urandom, $urandom};
            mask_in = mask;
            case (gnt_mode)
                0:       wr_gnt = 1'b0;
                1:       wr_gnt = 1'b1;
                default: wr_gnt = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (ready) begin
                exp_q.push_back(mk_exp(vl, addr, mask, result, k, words));
                k++;
            end
            @(posedge clk); #1;
            g++;
        end
        valid = 1'b0;
        chk("feed_accepted", 64'(k), 64'(last_idx));
    endtask

    task automatic finish_instr(input int d0, input int w0, input int words);
        int g;
        g = 0;
        wr_gnt = 1'b1;
        valid  = 1'b0;
        while (done_cnt == d0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        chk("done_pulse", 64'(done_cnt), 64'(d0 + 1));
        chk("write_count", 64'(write_cnt - w0), 64'(words));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("instr_ready_back", 64'(instr_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        int w0;
        int refused;
        d0 = done_cnt;
        w0 = write_cnt;
        start_instr(v.vl, v.addr);
        feed(v.vl, v.addr, v.mask, 0, v.words, v.words, v.gnt_mode);
        refused = 0;
        wr_gnt  = 1'b1;
        for (int j = 0; j < v.extra; j++) begin
            valid  = 1'b1;
            result = {$urandom, $urandom};
            @(negedge clk);
            if (!ready) refused++;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        if (v.extra > 0) chk("extra_refused", 64'(refused), 64'(v.extra));
        finish_instr(d0, w0, v.words);
        if (v.words > 0) chk("last_be", 64'(last_be), 64'(v.last_be));
    endtask

    initial begin
        int d0;
        int w0;
        int pushed;
        int stall_seen;
        int stable_bad;
        bit have_ref;
        logic [AW-1:0] ref_addr;
        logic [DW-1:0] ref_data;
        logic [SW-1:0] ref_be;

        //            vl     addr    mask  extra gnt words last_be
        vecs[0] = '{16'd24, 10'h010, 8'hFF, 0, 1, 3, 8'hFF};
        vecs[1] = '{16'd13, 10'h020, 8'hFF, 1, 1, 2, 8'h1F};
        vecs[2] = '{16'd0,  10'h030, 8'hFF, 0, 1, 0, 8'h00};
        vecs[3] = '{16'd8,  10'h040, 8'hA5, 1, 1, 1, 8'hA5};
        vecs[4] = '{16'd8,  10'h050, 8'h00, 0, 1, 1, 8'h00};
        vecs[5] = '{16'd16, 10'h080, 8'h00, 0, 1, 2, 8'h00};
        vecs[6] = '{16'd1,  10'h3FF, 8'hFF, 1, 1, 1, 8'h01};
        vecs[7] = '{16'd17, 10'h060, 8'hFF, 2, 2, 3, 8'h01};
        vecs[8] = '{16'd40, 10'h070, 8'h3C, 0, 2, 5, 8'h3C};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_instr_ready", 64'(instr_ready), 64'd1);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_wr_be", 64'(wr_be), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Grant stall with results streaming: FIFO fills to Depth and the payload holds.
        d0 = done_cnt;
        w0 = write_cnt;
        wr_gnt = 1'b0;
        start_instr(16'd32, 10'h100);
        pushed = 0;
        stall_seen = 0;
        stable_bad = 0;
        have_ref = 1'b0;
        ref_addr = '0;
        ref_data = '0;
        ref_be = '0;
        for (int i = 0; i < 6; i++) begin
            valid   = 1'b1;
            result  = {$urandom, $urandom};
            mask_in = 8'hFF;
            @(negedge clk);
            if (ready) begin
                exp_q.push_back(mk_exp(16'd32, 10'h100, 8'hFF, result, pushed, 4));
                pushed++;
            end
            if (wr_req) begin
                stall_seen++;
                if (!have_ref) begin
                    have_ref = 1'b1;
                    ref_addr = wr_addr;
                    ref_data = wr_data;
                    ref_be   = wr_be;
                end else if (wr_addr !== ref_addr || wr_data !== ref_data || wr_be !== ref_be) begin
                    stable_bad++;
                end
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
        @(negedge clk);
        chk("stall_accepted", 64'(pushed), 64'd2);
        chk("stall_req_cycles", 64'(stall_seen), 64'd5);
        chk("stall_payload_stable", 64'(stable_bad), 64'd0);
        chk("stall_ready_full", 64'(ready), 64'd0);
        chk("stall_cnt", 64'(stall_cnt), 64'(EXP_STALL));
        @(posedge clk); #1;
        feed(16'd32, 10'h100, 8'hFF, 2, 4, 4, 1);
        finish_instr(d0, w0, 4);

        // Reset mid-instruction with two entries pending.
        d0 = done_cnt;
        wr_gnt = 1'b0;
        start_instr(16'd32, 10'h200);
        feed(16'd32, 10'h200, 8'hFF, 0, 2, 4, 0);
        rst = 1'b1;
        exp_q.delete();
        done_due = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_wr_req", 64'(wr_req), 64'd0);
        chk("midrst_instr_ready", 64'(instr_ready), 64'd1);
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt), 64'(d0));
        @(posedge clk); #1;
        run_vec(vecs[0]);
        run_vec(vecs[7]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
